decode_scoreboard_stage: RTL and testbench

- Parametrised next-generation decode stage for the LC-3b pipeline.
- Replaces per-stage DR comparators with a counting scoreboard (one pending-write counter per register plus one for CC).
- Reads the internal register file with optional writeback bypass, and owns the registered DE->AGEX latch.
- Sits between the control-store lookup and the AGEX stage; the SR stage writes back into it.

---
 rtl/decode_scoreboard_stage.sv | 151 +++++++++++++++
 tb/tb_decode_scoreboard_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_scoreboard_stage.sv
// LC-3b decode stage: counting scoreboard for register/CC hazards, register file
// with optional writeback bypass, and the registered DE->AGEX latch.
module decode_scoreboard_stage #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int REG_ID_W = 3,
    parameter int CS_W     = 20,
    parameter int CNT_W    = 2,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                de_v,
    input  logic [DATA_W-1:0]   de_npc,
    input  logic [CS_W-1:0]     de_cs,
    input  logic [REG_ID_W-1:0] de_sr1_id,
    input  logic [REG_ID_W-1:0] de_sr2_id,
    input  logic [REG_ID_W-1:0] de_dr_id,
    input  logic                de_sr1_needed,
    input  logic                de_sr2_needed,
    input  logic                de_br_op,
    input  logic                de_ld_reg,
    input  logic                de_ld_cc,
    input  logic                mem_stall,
    input  logic                wb_v,
    input  logic                wb_ld_reg,
    input  logic                wb_ld_cc,
    input  logic [REG_ID_W-1:0] wb_dr_id,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                dep_stall,
    output logic                de_stall,
    output logic                agex_v,
    output logic [DATA_W-1:0]   agex_npc,
    output logic [DATA_W-1:0]   agex_sr1,
    output logic [DATA_W-1:0]   agex_sr2,
    output logic [REG_ID_W-1:0] agex_drid,
    output logic [CS_W-1:0]     agex_cs,
    output logic                agex_ld_reg,
    output logic                agex_ld_cc,
    output logic                sb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               BYP     = (BYPASS != 0);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [DATA_W-1:0]   rf_q  [NUM_REGS];
    logic [CNT_W-1:0]    cc_cnt_q, cc_cnt_d;
    logic                sb_err_q, sb_err_d;
    logic [NUM_REGS-1:0] busy, full, inc, dec;
    logic                wb_reg, wb_cc, cc_busy, cc_full, issue;
    logic [DATA_W-1:0]   sr1_data, sr2_data;

    logic                agex_v_q, agex_ld_reg_q, agex_ld_cc_q;
    logic [DATA_W-1:0]   agex_npc_q, agex_sr1_q, agex_sr2_q;
    logic [REG_ID_W-1:0] agex_drid_q;
    logic [CS_W-1:0]     agex_cs_q;

    // A spurious decrement is dropped, so a same-cycle increment still registers.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic i, input logic d);
        if (d && c == '0) return i ? CNT_ONE : '0;
        if (i && !d)      return c + CNT_ONE;
        if (d && !i)      return c - CNT_ONE;
        return c;
    endfunction

    assign wb_reg = wb_v & wb_ld_reg;
    assign wb_cc  = wb_v & wb_ld_cc;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            dec[r]  = wb_reg && (wb_dr_id == REG_ID_W'(r));
            busy[r] = (cnt_q[r] != '0) && !(BYP && dec[r] && cnt_q[r] == CNT_ONE);
            full[r] = (cnt_q[r] == CNT_MAX) && !dec[r];
        end
    end

    assign cc_busy = (cc_cnt_q != '0) && !(BYP && wb_cc && cc_cnt_q == CNT_ONE);
    assign cc_full = (cc_cnt_q == CNT_MAX) && !wb_cc;

    assign dep_stall = de_v & ((de_sr1_needed & busy[de_sr1_id]) |
                               (de_sr2_needed & busy[de_sr2_id]) |
                               (de_br_op & cc_busy) |
                               (de_ld_reg & full[de_dr_id]) |
                               (de_ld_cc & cc_full));
    assign issue     = de_v & ~dep_stall & ~mem_stall;
    assign de_stall  = de_v & ~issue;

    assign sr1_data = (BYP && wb_reg && wb_dr_id == de_sr1_id) ? wb_data : rf_q[de_sr1_id];
    assign sr2_data = (BYP && wb_reg && wb_dr_id == de_sr2_id) ? wb_data : rf_q[de_sr2_id];

    always_comb begin
        sb_err_d = sb_err_q | (wb_cc && cc_cnt_q == '0);
        cc_cnt_d = cnt_next(cc_cnt_q, issue & de_ld_cc, wb_cc);
        for (int r = 0; r < NUM_REGS; r++) begin
            inc[r]   = issue && de_ld_reg && (de_dr_id == REG_ID_W'(r));
            cnt_d[r] = cnt_next(cnt_q[r], inc[r], dec[r]);
            if (dec[r] && cnt_q[r] == '0) sb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
                rf_q[r]  <= '0;
            end
            cc_cnt_q <= '0;
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            cc_cnt_q <= cc_cnt_d;
            sb_err_q <= sb_err_d;
            if (wb_reg) rf_q[wb_dr_id] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            agex_v_q      <= 1'b0;
            agex_npc_q    <= '0;
            agex_sr1_q    <= '0;
            agex_sr2_q    <= '0;
            agex_drid_q   <= '0;
            agex_cs_q     <= '0;
            agex_ld_reg_q <= 1'b0;
            agex_ld_cc_q  <= 1'b0;
        end else if (!mem_stall) begin
            agex_v_q      <= issue;
            agex_npc_q    <= de_npc;
            agex_sr1_q    <= sr1_data;
            agex_sr2_q    <= sr2_data;
            agex_drid_q   <= de_dr_id;
            agex_cs_q     <= de_cs;
            agex_ld_reg_q <= issue & de_ld_reg;
            agex_ld_cc_q  <= issue & de_ld_cc;
        end
    end

    assign agex_v      = agex_v_q;
    assign agex_npc    = agex_npc_q;
    assign agex_sr1    = agex_sr1_q;
    assign agex_sr2    = agex_sr2_q;
    assign agex_drid   = agex_drid_q;
    assign agex_cs     = agex_cs_q;
    assign agex_ld_reg = agex_ld_reg_q;
    assign agex_ld_cc  = agex_ld_cc_q;
    assign sb_err      = sb_err_q;
endmodule

// File: tb/tb_decode_scoreboard_stage.sv
// Bench for decode_scoreboard_stage: one bypassing and one non-bypassing instance,
// driven by directed vectors, with a queue-based AGEX scoreboard.
module tb_decode_scoreboard_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nb_sel = 1'b0;
    logic        de_v = 0, de_sr1_needed = 0, de_sr2_needed = 0, de_br_op = 0;
    logic        de_ld_reg = 0, de_ld_cc = 0, mem_stall = 0;
    logic [15:0] de_npc = '0;
    logic [19:0] de_cs = '0;
    logic [2:0]  de_sr1_id = '0, de_sr2_id = '0, de_dr_id = '0, wb_dr_id = '0;
    logic        wb_v = 0, wb_ld_reg = 0, wb_ld_cc = 0;
    logic [15:0] wb_data = '0;

    logic b_de_v, b_wb_v, n_de_v, n_wb_v;
    assign b_de_v = de_v & ~nb_sel;
    assign b_wb_v = wb_v & ~nb_sel;
    assign n_de_v = de_v & nb_sel;
    assign n_wb_v = wb_v & nb_sel;

    logic        b_dep_stall, b_de_stall, b_agex_v, b_agex_ld_reg, b_agex_ld_cc, b_sb_err;
    logic [15:0] b_agex_npc, b_agex_sr1, b_agex_sr2;
    logic [2:0]  b_agex_drid;
    logic [19:0] b_agex_cs;
    logic        n_dep_stall, n_de_stall, n_agex_v, n_agex_ld_reg, n_agex_ld_cc, n_sb_err;
    logic [15:0] n_agex_npc, n_agex_sr1, n_agex_sr2;
    logic [2:0]  n_agex_drid;
    logic [19:0] n_agex_cs;

    always #5 clk = ~clk;

    decode_scoreboard_stage #(.BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .de_v(b_de_v), .de_npc(de_npc), .de_cs(de_cs),
        .de_sr1_id(de_sr1_id), .de_sr2_id(de_sr2_id), .de_dr_id(de_dr_id),
        .de_sr1_needed(de_sr1_needed), .de_sr2_needed(de_sr2_needed), .de_br_op(de_br_op),
        .de_ld_reg(de_ld_reg), .de_ld_cc(de_ld_cc), .mem_stall(mem_stall),
        .wb_v(b_wb_v), .wb_ld_reg(wb_ld_reg), .wb_ld_cc(wb_ld_cc), .wb_dr_id(wb_dr_id),
        .wb_data(wb_data), .dep_stall(b_dep_stall), .de_stall(b_de_stall),
        .agex_v(b_agex_v), .agex_npc(b_agex_npc), .agex_sr1(b_agex_sr1),
        .agex_sr2(b_agex_sr2), .agex_drid(b_agex_drid), .agex_cs(b_agex_cs),
        .agex_ld_reg(b_agex_ld_reg), .agex_ld_cc(b_agex_ld_cc), .sb_err(b_sb_err));

    decode_scoreboard_stage #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .de_v(n_de_v), .de_npc(de_npc), .de_cs(de_cs),
        .de_sr1_id(de_sr1_id), .de_sr2_id(de_sr2_id), .de_dr_id(de_dr_id),
        .de_sr1_needed(de_sr1_needed), .de_sr2_needed(de_sr2_needed), .de_br_op(de_br_op),
        .de_ld_reg(de_ld_reg), .de_ld_cc(de_ld_cc), .mem_stall(mem_stall),
        .wb_v(n_wb_v), .wb_ld_reg(wb_ld_reg), .wb_ld_cc(wb_ld_cc), .wb_dr_id(wb_dr_id),
        .wb_data(wb_data), .dep_stall(n_dep_stall), .de_stall(n_de_stall),
        .agex_v(n_agex_v), .agex_npc(n_agex_npc), .agex_sr1(n_agex_sr1),
        .agex_sr2(n_agex_sr2), .agex_drid(n_agex_drid), .agex_cs(n_agex_cs),
        .agex_ld_reg(n_agex_ld_reg), .agex_ld_cc(n_agex_ld_cc), .sb_err(n_sb_err));

    typedef struct {
        logic [15:0] npc, sr1, sr2;
        logic [2:0]  drid;
        logic [19:0] cs;
        logic        ld_reg, ld_cc;
        string       tag;
    } txn_t;

    txn_t q_b[$];
    txn_t q_n[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_check(input bit nb, input logic [15:0] npc, input logic [15:0] sr1,
                             input logic [15:0] sr2, input logic [2:0] drid,
                             input logic [19:0] cs, input logic lr, input logic lc);
        txn_t e;
        if ((nb && q_n.size() == 0) || (!nb && q_b.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_agex: got agex_v=1 npc %0h expected no transaction", npc);
            return;
        end
        if (nb) e = q_n.pop_front();
        else    e = q_b.pop_front();
        chk({e.tag, "_npc"},    npc,  e.npc);
        chk({e.tag, "_sr1"},    sr1,  e.sr1);
        chk({e.tag, "_sr2"},    sr2,  e.sr2);
        chk({e.tag, "_drid"},   drid, e.drid);
        chk({e.tag, "_cs"},     cs,   e.cs);
        chk({e.tag, "_ld_reg"}, lr,   e.ld_reg);
        chk({e.tag, "_ld_cc"},  lc,   e.ld_cc);
    endtask

    // New AGEX contents appear only after an edge where the latch was not held.
    always @(posedge clk) begin : monitor
        logic held;
        held = mem_stall | ~rst_n;
        #1;
        if (b_agex_v && !held)
            mon_check(1'b0, b_agex_npc, b_agex_sr1, b_agex_sr2, b_agex_drid, b_agex_cs,
                      b_agex_ld_reg, b_agex_ld_cc);
        if (n_agex_v && !held)
            mon_check(1'b1, n_agex_npc, n_agex_sr1, n_agex_sr2, n_agex_drid, n_agex_cs,
                      n_agex_ld_reg, n_agex_ld_cc);
    end

    task automatic set_de(input logic v, input logic s1n, input logic [2:0] s1,
                          input logic s2n, input logic [2:0] s2, input logic br,
                          input logic ldr, input logic [2:0] dr, input logic ldc,
                          input logic [15:0] npc);
        de_v = v; de_sr1_needed = s1n; de_sr1_id = s1; de_sr2_needed = s2n; de_sr2_id = s2;
        de_br_op = br; de_ld_reg = ldr; de_dr_id = dr; de_ld_cc = ldc;
        de_npc = npc; de_cs = {4'hA, npc};
    endtask

    task automatic set_wb(input logic v, input logic ldr, input logic ldc,
                          input logic [2:0] id, input logic [15:0] d);
        wb_v = v; wb_ld_reg = ldr; wb_ld_cc = ldc; wb_dr_id = id; wb_data = d;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic cyc(input string name, input logic exp_dep, input logic exp_iss,
                       input logic [15:0] e_sr1, input logic [15:0] e_sr2);
        txn_t t;
        #1;
        if (nb_sel) begin
            chk({name, "_dep_stall"}, n_dep_stall, exp_dep);
            chk({name, "_de_stall"},  n_de_stall,  de_v & ~exp_iss);
        end else begin
            chk({name, "_dep_stall"}, b_dep_stall, exp_dep);
            chk({name, "_de_stall"},  b_de_stall,  de_v & ~exp_iss);
        end
        if (exp_iss) begin
            t.npc = de_npc; t.sr1 = e_sr1; t.sr2 = e_sr2; t.drid = de_dr_id; t.cs = de_cs;
            t.ld_reg = de_ld_reg; t.ld_cc = de_ld_cc; t.tag = name;
            if (nb_sel) q_n.push_back(t);
            else        q_b.push_back(t);
        end
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_agex_v",   b_agex_v,    0);
        chk("rst_agex_npc", b_agex_npc,  0);
        chk("rst_sb_err",   b_sb_err,    0);
        chk("rst_nb_agex_v", n_agex_v,   0);
        @(negedge clk);
        rst_n = 1'b1;

        set_de(1, 1, 0, 0, 0, 0, 1, 1, 0, 16'h3000);
        cyc("add_r1", 0, 1, 16'h0, 16'h0);
        chk("add_r1_agex_v", b_agex_v, 1);
        chk("add_r1_agex_drid", b_agex_drid, 1);
        set_de(1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h3002);
        cyc("raw_r1_a", 1, 0, 16'h0, 16'h0);
        cyc("raw_r1_b", 1, 0, 16'h0, 16'h0);
        set_de(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h3002);
        set_wb(1, 1, 0, 1, 16'h1111);
        cyc("wb_r1", 0, 0, 16'h0, 16'h0);
        set_wb(0, 0, 0, 0, 16'h0);
        set_de(1, 1, 1, 0, 0, 0, 0, 0, 0, 16'h3004);
        cyc("rd_r1", 0, 1, 16'h1111, 16'h0);

        set_de(1, 0, 0, 0, 0, 0, 1, 2, 0, 16'h3006);
        cyc("wr_r2", 0, 1, 16'h0, 16'h0);
        set_de(1, 1, 2, 1, 1, 0, 0, 0, 0, 16'h3008);
        set_wb(1, 1, 0, 2, 16'hBEEF);
        cyc("byp_r2", 0, 1, 16'hBEEF, 16'h1111);
        set_wb(0, 0, 0, 0, 16'h0);

        for (int i = 0; i < 3; i++) begin
            set_de(1, 0, 0, 0, 0, 0, 1, 3, 0, 16'h3010 + 16'(2 * i));
            cyc("wr_r3", 0, 1, 16'h0, 16'h0);
        end
        set_de(1, 0, 0, 0, 0, 0, 1, 3, 0, 16'h3016);
        cyc("full_r3", 1, 0, 16'h0, 16'h0);
        set_wb(1, 1, 0, 3, 16'h3333);
        cyc("full_r3_dec", 0, 1, 16'h0, 16'h0);
        set_wb(0, 0, 0, 0, 16'h0);
        set_de(1, 0, 0, 0, 0, 0, 1, 3, 0, 16'h3018);
        cyc("full_r3_again", 1, 0, 16'h0, 16'h0);
        set_de(1, 1, 3, 0, 0, 0, 0, 0, 0, 16'h301A);
        set_wb(1, 1, 0, 3, 16'h3334);
        cyc("waw_r3_a", 1, 0, 16'h0, 16'h0);
        set_wb(1, 1, 0, 3, 16'h3335);
        cyc("waw_r3_b", 1, 0, 16'h0, 16'h0);
        set_wb(1, 1, 0, 3, 16'h3336);
        cyc("waw_r3_c", 0, 1, 16'h3336, 16'h0);
        set_wb(0, 0, 0, 0, 16'h0);

        set_de(1, 0, 0, 0, 0, 0, 1, 4, 1, 16'h3020);
        cyc("wr_cc", 0, 1, 16'h0, 16'h0);
        set_de(1, 0, 0, 0, 0, 1, 0, 0, 0, 16'h3022);
        cyc("br_wait", 1, 0, 16'h0, 16'h0);
        set_wb(1, 0, 1, 0, 16'h0);
        cyc("br_byp", 0, 1, 16'h0, 16'h0);
        set_de(1, 1, 4, 0, 0, 0, 0, 0, 0, 16'h3024);
        set_wb(1, 1, 0, 4, 16'h4444);
        cyc("byp_r4", 0, 1, 16'h4444, 16'h0);
        set_wb(0, 0, 0, 0, 16'h0);

        mem_stall = 1'b1;
        set_de(1, 1, 1, 0, 0, 0, 1, 6, 0, 16'h3026);
        for (int i = 0; i < 3; i++) begin
            cyc("mstall", 0, 0, 16'h0, 16'h0);
            chk("mstall_agex_v",   b_agex_v,   1);
            chk("mstall_agex_npc", b_agex_npc, 16'h3024);
            chk("mstall_agex_sr1", b_agex_sr1, 16'h4444);
        end
        mem_stall = 1'b0;
        cyc("mstall_rel", 0, 1, 16'h1111, 16'h0);
        set_de(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        set_wb(1, 1, 0, 6, 16'h6666);
        cyc("wb_r6", 0, 0, 16'h0, 16'h0);
        set_wb(0, 0, 0, 0, 16'h0);
        set_de(1, 1, 6, 0, 0, 0, 0, 0, 0, 16'h3028);
        cyc("rd_r6", 0, 1, 16'h6666, 16'h0);
        chk("sb_err_clean", b_sb_err, 0);

        set_de(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        set_wb(1, 1, 0, 5, 16'h5555);
        cyc("spur_r5", 0, 0, 16'h0, 16'h0);
        set_wb(0, 0, 0, 0, 16'h0);
        chk("sb_err_set", b_sb_err, 1);
        cyc("idle", 0, 0, 16'h0, 16'h0);
        chk("sb_err_sticky", b_sb_err, 1);

        set_de(1, 0, 0, 0, 0, 0, 1, 7, 0, 16'h302A);
        cyc("wr_r7", 0, 1, 16'h0, 16'h0);
        set_de(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        rst_n = 1'b0;
        #2;
        chk("midrst_sb_err", b_sb_err, 0);
        chk("midrst_agex_v", b_agex_v, 0);
        chk("midrst_agex_npc", b_agex_npc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_wb(1, 1, 0, 7, 16'h7777);
        cyc("post_rst_wb", 0, 0, 16'h0, 16'h0);
        set_wb(0, 0, 0, 0, 16'h0);
        chk("post_rst_sb_err", b_sb_err, 1);

        rst_n = 1'b0;
        nb_sel = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        set_de(1, 0, 0, 0, 0, 0, 1, 2, 0, 16'h4000);
        cyc("nb_wr_r2", 0, 1, 16'h0, 16'h0);
        set_de(1, 1, 2, 0, 0, 0, 0, 0, 0, 16'h4002);
        set_wb(1, 1, 0, 2, 16'hBEEF);
        cyc("nb_rd_r2_wb", 1, 0, 16'h0, 16'h0);
        set_wb(0, 0, 0, 0, 16'h0);
        cyc("nb_rd_r2", 0, 1, 16'hBEEF, 16'h0);
        set_de(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h4004);
        cyc("nb_wr_cc", 0, 1, 16'h0, 16'h0);
        set_de(1, 0, 0, 0, 0, 1, 0, 0, 0, 16'h4006);
        set_wb(1, 0, 1, 0, 16'h0);
        cyc("nb_br_wb", 1, 0, 16'h0, 16'h0);
        set_wb(0, 0, 0, 0, 16'h0);
        cyc("nb_br", 0, 1, 16'h0, 16'h0);
        set_de(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        repeat (3) @(negedge clk);
        chk("nb_sb_err", n_sb_err, 0);
        chk("q_b_drained", q_b.size(), 0);
        chk("q_n_drained", q_n.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
